// File: rtl/pb_conditioner.sv
// pb_conditioner
//   Pushbutton / switch input conditioner. Each pushbutton passes through a
//   2-flop synchroniser, a debounce counter and a RELEASED/HELD state machine.
//   The result is a one-cycle press strobe plus a debounced level. Switches
//   only pass through a 2-flop synchroniser.
//
//   Optional feature macro: PB_AUTOREPEAT_EN
//     When defined, this adds the RPT_DELAY and RPT_RATE parameters. A held
//     button then re-strobes pb_pulse RPT_DELAY cycles after the press, and
//     every RPT_RATE cycles after that until it is released.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   pb_raw    in   [NUM_PB-1:0] raw pushbutton pins (active high, bouncy)
//   sw_raw    in   [SW_W-1:0]   raw switch pins
//   pb_pulse  out  [NUM_PB-1:0] one-cycle strobe per accepted press
//   pb_level  out  [NUM_PB-1:0] debounced button level (1 = held)
//   sw_sync   out  [SW_W-1:0]   synchronised switch value
module pb_conditioner #(
  parameter int NUM_PB    = 5,
  parameter int DB_CYCLES = 1000000,
  parameter int CNT_W     = 20,
  parameter int SW_W      = 4
`ifdef PB_AUTOREPEAT_EN
  ,
  parameter int RPT_DELAY = 25000000,
  parameter int RPT_RATE  = 5000000
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_PB-1:0] pb_raw,
  input  logic [SW_W-1:0]   sw_raw,
  output logic [NUM_PB-1:0] pb_pulse,
  output logic [NUM_PB-1:0] pb_level,
  output logic [SW_W-1:0]   sw_sync
);

  typedef enum logic {
    RELEASED = 1'b0,
    HELD     = 1'b1
  } pb_state_t;

  // The last count value before the level change is accepted.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

`ifdef PB_AUTOREPEAT_EN
  localparam logic [31:0] RPT_DELAY_MAX = 32'(RPT_DELAY - 1);
  localparam logic [31:0] RPT_RATE_MAX  = 32'(RPT_RATE - 1);
`endif

  logic [NUM_PB-1:0] pb_s1_r;
  logic [NUM_PB-1:0] pb_s2_r;
  logic [SW_W-1:0]   sw_s1_r;
  logic [SW_W-1:0]   sw_s2_r;

  // Two-flop synchronisers for every button and switch pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pb_s1_r <= {NUM_PB{1'b0}};
      pb_s2_r <= {NUM_PB{1'b0}};
      sw_s1_r <= {SW_W{1'b0}};
      sw_s2_r <= {SW_W{1'b0}};
    end else begin
      pb_s1_r <= pb_raw;
      pb_s2_r <= pb_s1_r;
      sw_s1_r <= sw_raw;
      sw_s2_r <= sw_s1_r;
    end
  end

  assign sw_sync = sw_s2_r;

  genvar g;
  generate
    for (g = 0; g < NUM_PB; g++) begin : g_ch
      pb_state_t        state_r;
      pb_state_t        state_nxt_s;
      logic [CNT_W-1:0] cnt_r;
      logic [CNT_W-1:0] cnt_nxt_s;
      logic             pulse_r;
      logic             pulse_nxt_s;
`ifdef PB_AUTOREPEAT_EN
      logic [31:0]      rpt_r;
      logic [31:0]      rpt_nxt_s;
      logic             rpt_phase_r;      // 0: waiting for the first repeat, 1: repeating at RPT_RATE
      logic             rpt_phase_nxt_s;
`endif

      // Next-state, debounce count and press strobe for this channel.
      always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        pulse_nxt_s = 1'b0;
`ifdef PB_AUTOREPEAT_EN
        rpt_nxt_s       = rpt_r;
        rpt_phase_nxt_s = rpt_phase_r;
`endif
        case (state_r)
          RELEASED: begin
`ifdef PB_AUTOREPEAT_EN
            rpt_nxt_s       = 32'd0;
            rpt_phase_nxt_s = 1'b0;
`endif
            if (pb_s2_r[g] && (cnt_r == CNT_MAX)) begin
              state_nxt_s = HELD;
              cnt_nxt_s   = {CNT_W{1'b0}};
              pulse_nxt_s = 1'b1;
            end else begin
              // Any sample that matches the current level restarts the count.
              cnt_nxt_s = pb_s2_r[g] ? (cnt_r + CNT_W'(1)) : {CNT_W{1'b0}};
            end
          end
          HELD: begin
            if (!pb_s2_r[g] && (cnt_r == CNT_MAX)) begin
              // Release wins over a repeat that falls on the same edge.
              state_nxt_s = RELEASED;
              cnt_nxt_s   = {CNT_W{1'b0}};
`ifdef PB_AUTOREPEAT_EN
              rpt_nxt_s       = 32'd0;
              rpt_phase_nxt_s = 1'b0;
`endif
            end else begin
              cnt_nxt_s = pb_s2_r[g] ? {CNT_W{1'b0}} : (cnt_r + CNT_W'(1));
`ifdef PB_AUTOREPEAT_EN
              if (rpt_r == (rpt_phase_r ? RPT_RATE_MAX : RPT_DELAY_MAX)) begin
                pulse_nxt_s     = 1'b1;
                rpt_nxt_s       = 32'd0;
                rpt_phase_nxt_s = 1'b1;
              end else begin
                rpt_nxt_s = rpt_r + 32'd1;
              end
`endif
            end
          end
          default: begin
            state_nxt_s = RELEASED;
            cnt_nxt_s   = {CNT_W{1'b0}};
          end
        endcase
      end

      // Channel state, counters and registered strobe.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_r <= RELEASED;
          cnt_r   <= {CNT_W{1'b0}};
          pulse_r <= 1'b0;
`ifdef PB_AUTOREPEAT_EN
          rpt_r       <= 32'd0;
          rpt_phase_r <= 1'b0;
`endif
        end else begin
          state_r <= state_nxt_s;
          cnt_r   <= cnt_nxt_s;
          pulse_r <= pulse_nxt_s;
`ifdef PB_AUTOREPEAT_EN
          rpt_r       <= rpt_nxt_s;
          rpt_phase_r <= rpt_phase_nxt_s;
`endif
        end
      end

      assign pb_pulse[g] = pulse_r;
      assign pb_level[g] = (state_r == HELD);
    end
  endgenerate

endmodule

// File: tb/tb_pb_conditioner.sv
module tb_pb_conditioner;

  localparam int NUM_PB = 5;
  localparam int SW_W   = 4;
  localparam int DB     = 4;
`ifdef PB_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_PB-1:0] pb_raw;
  logic [SW_W-1:0]   sw_raw;
  logic [NUM_PB-1:0] pb_pulse;
  logic [NUM_PB-1:0] pb_level;
  logic [SW_W-1:0]   sw_sync;

  int total = 0;
  int bad   = 0;

  pb_conditioner #(
    .NUM_PB(NUM_PB), .DB_CYCLES(DB), .CNT_W(4), .SW_W(SW_W)
`ifdef PB_AUTOREPEAT_EN
    , .RPT_DELAY(8), .RPT_RATE(3)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .pb_raw(pb_raw), .sw_raw(sw_raw),
    .pb_pulse(pb_pulse), .pb_level(pb_level), .sw_sync(sw_sync)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    pb_raw = 5'b11111;
    sw_raw = 4'hF;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if ({pb_pulse, pb_level, sw_sync} !== 14'd0) begin
        bad++;
        $display("FAIL reset_hold k=%0d got pulse=%b level=%b sw=%h want all 0", k, pb_pulse, pb_level, sw_sync);
      end
    end
    rst_n = 1'b1;
    step();
    total++;
    if ({pb_pulse, pb_level, sw_sync} !== 14'd0) begin
      bad++;
      $display("FAIL reset_first_edge got pulse=%b level=%b sw=%h want all 0", pb_pulse, pb_level, sw_sync);
    end
    pb_raw = 5'b00000;
    sw_raw = 4'h0;
    for (int k = 0; k < 8; k++) begin
      step();
      total++;
      if ({pb_pulse, pb_level} !== 10'd0) begin
        bad++;
        $display("FAIL reset_settle k=%0d got pulse=%b level=%b want 0", k, pb_pulse, pb_level);
      end
    end
  endtask

  // Press at edge 0, release sampled at edge 20, level falls after edge 25.
  task automatic test_clean_press();
    logic [NUM_PB-1:0] ep, el;
    pb_raw[0] = 1'b1;
    for (int k = 0; k < 32; k++) begin
      step();
      if (k == 19) pb_raw[0] = 1'b0;
      ep = '0;
      el = '0;
      ep[0] = (k == 5) || (AR && k >= 13 && k < 25 && ((k - 13) % 3) == 0);
      el[0] = (k >= 5) && (k < 25);
      total++;
      if (pb_pulse !== ep || pb_level !== el) begin
        bad++;
        $display("FAIL clean_press k=%0d got pulse=%b level=%b want pulse=%b level=%b", k, pb_pulse, pb_level, ep, el);
      end
    end
  endtask

  task automatic test_bounce();
    logic [4:0] pat;
    logic [NUM_PB-1:0] ep, el;
    pat = 5'b10101;  // bit k drives edge k
    for (int k = 0; k < 15; k++) begin
      pb_raw[2] = (k < 5) ? pat[k] : 1'b1;
      step();
      ep = '0;
      el = '0;
      ep[2] = (k == 9);
      el[2] = (k >= 9);
      total++;
      if (pb_pulse !== ep || pb_level !== el) begin
        bad++;
        $display("FAIL bounce k=%0d got pulse=%b level=%b want pulse=%b level=%b", k, pb_pulse, pb_level, ep, el);
      end
    end
    // 2-cycle release glitch must be rejected.
    for (int k = 0; k < 10; k++) begin
      pb_raw[2] = (k < 2) ? 1'b0 : 1'b1;
      step();
      total++;
      if (pb_level[2] !== 1'b1) begin
        bad++;
        $display("FAIL bounce_glitch k=%0d got level=%b want 1", k, pb_level[2]);
      end
    end
    pb_raw[2] = 1'b0;
    for (int k = 0; k < 8; k++) step();
    total++;
    if (pb_level !== 5'b00000) begin
      bad++;
      $display("FAIL bounce_release got level=%b want 00000", pb_level);
    end
  endtask

  task automatic test_simultaneous();
    logic [NUM_PB-1:0] ep;
    pb_raw = 5'b10001;
    for (int k = 0; k < 8; k++) begin
      step();
      ep = (k == 5) ? 5'b10001 : 5'b00000;
      total++;
      if (pb_pulse !== ep) begin
        bad++;
        $display("FAIL simultaneous k=%0d got pulse=%b want %b", k, pb_pulse, ep);
      end
    end
    pb_raw = 5'b00000;
    for (int k = 0; k < 8; k++) step();
    total++;
    if (pb_level !== 5'b00000) begin
      bad++;
      $display("FAIL simultaneous_release got level=%b want 00000", pb_level);
    end
  endtask

  task automatic test_reset_mid_debounce();
    logic [NUM_PB-1:0] ep;
    pb_raw[1] = 1'b1;
    // Count reaches 2 at edge 3.
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if (pb_pulse !== 5'b00000) begin
        bad++;
        $display("FAIL mid_pre k=%0d got pulse=%b want 00000", k, pb_pulse);
      end
    end
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if ({pb_pulse, pb_level} !== 10'd0) begin
        bad++;
        $display("FAIL mid_in_reset k=%0d got pulse=%b level=%b want 0", k, pb_pulse, pb_level);
      end
    end
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      ep = '0;
      ep[1] = (k == 5);
      total++;
      if (pb_pulse !== ep) begin
        bad++;
        $display("FAIL mid_post k=%0d got pulse=%b want %b", k, pb_pulse, ep);
      end
    end
    pb_raw[1] = 1'b0;
    for (int k = 0; k < 8; k++) step();
  endtask

  task automatic test_switch();
    sw_raw = 4'h3;
    for (int k = 0; k < 3; k++) step();
    total++;
    if (sw_sync !== 4'h3) begin
      bad++;
      $display("FAIL sw_initial got %h want 3", sw_sync);
    end
    sw_raw = 4'hA;
    step();
    total++;
    if (sw_sync !== 4'h3) begin
      bad++;
      $display("FAIL sw_edge1 got %h want 3", sw_sync);
    end
    step();
    total++;
    if (sw_sync !== 4'hA) begin
      bad++;
      $display("FAIL sw_edge2 got %h want a", sw_sync);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid_debounce();
    test_switch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
